// File: rtl/secuenciador_control.sv
// rtl/secuenciador_control.sv - multi-cycle fetch/decode control unit for unidad_procesadora
module secuenciador_control #(
  parameter int PC_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  input  logic [3:0]      flags,
  output logic [15:0]     control,
  input  logic            in_valid,
  output logic            in_ack,
  output logic            out_valid,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_SHF  = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_OUT  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_BR   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  state_t          state, state_nxt;
  logic [15:0]     ir, ir_nxt;
  logic [3:0]      flag_reg, flag_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            br_flag;

  // Instruction fields; flags are ordered {V,N,Z,C}.
  logic [3:0]      op;
  logic [1:0]      rd, ra, rb;
  logic [PC_W-1:0] target;

  assign op     = ir[15:12];
  assign rd     = ir[11:10];
  assign ra     = ir[9:8];
  assign rb     = ir[7:6];
  assign target = ir[PC_W-1:0];

  // State, program counter, instruction and latched flags registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      flag_reg <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      flag_reg <= flag_nxt;
    end
  end

  // Branch condition select on the latched flags (never the live input).
  always_comb begin
    br_flag = 1'b0;
    case (ir[11:10])
      2'b00:   br_flag = flag_reg[1];  // Z
      2'b01:   br_flag = flag_reg[2];  // N
      2'b10:   br_flag = flag_reg[0];  // C
      default: br_flag = flag_reg[3];  // V
    endcase
  end

  // Next-state, next register values and the decoded control outputs.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    flag_nxt  = flag_reg;
    control   = 16'h0000;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;

    case (state)
      IDLE, HALT: begin
        halted = (state == HALT);
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
          flag_nxt  = '0;
        end
      end

      FETCH: begin
        busy      = 1'b1;
        ir_nxt    = instr;
        pc_nxt    = pc + PC_W'(1);
        state_nxt = EXEC;
      end

      EXEC: begin
        busy      = 1'b1;
        state_nxt = FETCH;
        case (op)
          OP_ALU: begin
            control  = {ra, rb, rd, 1'b1, 1'b0, ir[5:2], 2'b00, 1'b0, 1'b0};
            flag_nxt = flags;
          end
          OP_SHF: begin
            control  = {2'b00, rb, rd, 1'b1, 1'b0, 4'b0000, ir[1:0], 1'b1, 1'b0};
            flag_nxt = flags;
          end
          OP_LDI: begin
            // Hold in EXEC until the host offers a value; write on that cycle.
            control = {2'b00, 2'b00, rd, in_valid, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1};
            in_ack  = in_valid;
            if (!in_valid) begin
              state_nxt = EXEC;
            end
          end
          OP_OUT: begin
            control   = {2'b00, rb, 12'b0001_0000_0000};
            out_valid = 1'b1;
          end
          OP_JMP: begin
            pc_nxt = target;
          end
          OP_BR: begin
            if (br_flag) begin
              pc_nxt = target;
            end
          end
          OP_HALT: begin
            state_nxt = HALT;
          end
          default: begin
            // OP_NOP and 8..15: no datapath activity.
          end
        endcase
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_secuenciador_control.sv
// tb/tb_secuenciador_control.sv - scoreboard bench for secuenciador_control
module tb_secuenciador_control;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [3:0]  flags;
  logic        in_valid;

  logic [5:0]  pc0;
  logic [15:0] instr0, control0;
  logic        in_ack0, out_valid0, busy0, halted0;

  logic [1:0]  pc1;
  logic [15:0] instr1, control1;
  logic        in_ack1, out_valid1, busy1, halted1;

  logic [15:0] rom0 [0:63];
  logic [15:0] rom1 [0:3];

  assign instr0 = rom0[pc0];
  assign instr1 = rom1[pc1];

  secuenciador_control #(.PC_W(6)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pc(pc0), .instr(instr0),
    .flags(flags), .control(control0), .in_valid(in_valid), .in_ack(in_ack0),
    .out_valid(out_valid0), .busy(busy0), .halted(halted0)
  );

  secuenciador_control #(.PC_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pc(pc1), .instr(instr1),
    .flags(flags), .control(control1), .in_valid(in_valid), .in_ack(in_ack1),
    .out_valid(out_valid1), .busy(busy1), .halted(halted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          dut;
    int          pc;
    logic [15:0] ctl;
    logic        ack;
    logic        ov;
    logic        bsy;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  int          a_pc;
  logic [15:0] a_ctl;
  logic        a_ack, a_ov, a_bsy, a_hlt;

  // Monitor: compares the DUT outputs against every expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      if (m_e.dut == 0) begin
        a_pc = int'(pc0); a_ctl = control0; a_ack = in_ack0;
        a_ov = out_valid0; a_bsy = busy0; a_hlt = halted0;
      end else begin
        a_pc = int'(pc1); a_ctl = control1; a_ack = in_ack1;
        a_ov = out_valid1; a_bsy = busy1; a_hlt = halted1;
      end
      checks++;
      if (m_e.cyc != cyc || a_pc != m_e.pc || a_ctl !== m_e.ctl || a_ack !== m_e.ack ||
          a_ov !== m_e.ov || a_bsy !== m_e.bsy || a_hlt !== m_e.hlt) begin
        errors++;
        $display("FAIL dut%0d_cyc%0d (at cyc %0d): got pc=%0d ctl=%h ack=%b ov=%b busy=%b halted=%b, want pc=%0d ctl=%h ack=%b ov=%b busy=%b halted=%b",
                 m_e.dut, m_e.cyc, cyc, a_pc, a_ctl, a_ack, a_ov, a_bsy, a_hlt,
                 m_e.pc, m_e.ctl, m_e.ack, m_e.ov, m_e.bsy, m_e.hlt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int target_cyc);
    while (cyc < target_cyc) tick();
  endtask

  task automatic expect_at(input int d, input int dut, input int pcv, input logic [15:0] ctl,
                           input logic ack, input logic ov, input logic bsy, input logic hlt);
    exp_t e;
    e.cyc = cyc + d; e.dut = dut; e.pc = pcv; e.ctl = ctl;
    e.ack = ack; e.ov = ov; e.bsy = bsy; e.hlt = hlt;
    q.push_back(e);
  endtask

  int c, e0, guard;

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; flags = 4'b0000;
    for (int i = 0; i < 64; i++) rom0[i] = 16'h0000;
    rom0[0]  = 16'h19D4;  // ALU rd=2 ra=1 rb=3 aluop=0101
    rom0[1]  = 16'h6014;  // BR Z -> 20
    rom0[20] = 16'h4080;  // OUT rb=2
    rom0[21] = 16'h3400;  // LDI rd=1
    rom0[22] = 16'h19D4;  // ALU again, flags now 0
    rom0[23] = 16'h6014;  // BR Z -> 20, not taken
    rom0[24] = 16'h2C42;  // SHF rd=3 rb=1 sh=10
    rom0[25] = 16'h7000;  // HALT
    rom1[0] = 16'h0000; rom1[1] = 16'h0000; rom1[2] = 16'h0000; rom1[3] = 16'h7000;

    repeat (3) tick();
    expect_at(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    expect_at(0, 1, 0, 16'h0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    c = cyc;
    flags  = 4'b0010;
    start0 = 1'b1;
    expect_at(1,  0, 0,  16'h0000, 0, 0, 1, 0);
    expect_at(2,  0, 1,  16'h7A50, 0, 0, 1, 0);
    expect_at(3,  0, 1,  16'h0000, 0, 0, 1, 0);
    expect_at(4,  0, 2,  16'h0000, 0, 0, 1, 0);
    expect_at(5,  0, 20, 16'h0000, 0, 0, 1, 0);
    expect_at(6,  0, 21, 16'h2100, 0, 1, 1, 0);
    expect_at(7,  0, 21, 16'h0000, 0, 0, 1, 0);
    expect_at(8,  0, 22, 16'h0401, 0, 0, 1, 0);
    expect_at(9,  0, 22, 16'h0401, 0, 0, 1, 0);
    expect_at(10, 0, 22, 16'h0401, 0, 0, 1, 0);
    expect_at(11, 0, 22, 16'h0601, 1, 0, 1, 0);
    expect_at(12, 0, 22, 16'h0000, 0, 0, 1, 0);
    expect_at(13, 0, 23, 16'h7A50, 0, 0, 1, 0);
    expect_at(14, 0, 23, 16'h0000, 0, 0, 1, 0);
    expect_at(15, 0, 24, 16'h0000, 0, 0, 1, 0);
    expect_at(16, 0, 24, 16'h0000, 0, 0, 1, 0);
    expect_at(17, 0, 25, 16'h1E0A, 0, 0, 1, 0);
    expect_at(18, 0, 25, 16'h0000, 0, 0, 1, 0);
    expect_at(19, 0, 26, 16'h0000, 0, 0, 1, 0);
    expect_at(20, 0, 26, 16'h0000, 0, 0, 0, 1);
    expect_at(21, 0, 26, 16'h0000, 0, 0, 0, 1);
    expect_at(22, 0, 0,  16'h0000, 0, 0, 1, 0);

    at(c + 1);  start0 = 1'b0;
    at(c + 5);  flags = 4'b0000;
    at(c + 9);  start0 = 1'b1;   // ignored while busy
    at(c + 10); start0 = 1'b0;
    at(c + 11); in_valid = 1'b1;
    at(c + 12); in_valid = 1'b0;
    at(c + 21); start0 = 1'b1;   // restart from HALT
    at(c + 22); start0 = 1'b0;
    at(c + 23);                  // EXEC of ALU: reset lands mid-cycle
    rst_n = 1'b0;
    expect_at(0, 0, 0, 16'h0000, 0, 0, 0, 0);
    at(c + 24);
    rst_n = 1'b1;
    expect_at(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    at(c + 26);

    e0 = cyc;
    start1 = 1'b1;
    expect_at(1,  1, 0, 16'h0000, 0, 0, 1, 0);
    expect_at(2,  1, 1, 16'h0000, 0, 0, 1, 0);
    expect_at(3,  1, 1, 16'h0000, 0, 0, 1, 0);
    expect_at(4,  1, 2, 16'h0000, 0, 0, 1, 0);
    expect_at(5,  1, 2, 16'h0000, 0, 0, 1, 0);
    expect_at(6,  1, 3, 16'h0000, 0, 0, 1, 0);
    expect_at(7,  1, 3, 16'h0000, 0, 0, 1, 0);
    expect_at(8,  1, 0, 16'h0000, 0, 0, 1, 0);
    expect_at(9,  1, 0, 16'h0000, 0, 0, 0, 1);
    expect_at(10, 1, 0, 16'h0000, 0, 0, 0, 1);
    expect_at(11, 1, 0, 16'h0000, 0, 0, 1, 0);
    expect_at(12, 1, 1, 16'h0000, 0, 0, 1, 0);
    at(e0 + 1);  start1 = 1'b0;
    at(e0 + 10); start1 = 1'b1;
    at(e0 + 11); start1 = 1'b0;
    at(e0 + 13);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (q.size() > 0) begin
      checks += q.size();
      errors += q.size();
      $display("FAIL scoreboard_drain: %0d expectations still pending, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
